// File: rtl/prefix_addsub_pkg.sv
// Shared constants and helpers for the pipelined Kogge-Stone adder/subtractor.
package prefix_addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  // Number of prefix levels needed to span a word of the given width.
  function automatic int prefix_levels(input int width);
    int n;
    int w;
    n = 0;
    w = 1;
    while (w < width) begin
      w = w * 2;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/prefix_cell.sv
// Kogge-Stone black cell: merges a high {g,p} span with the adjacent lower span.
module prefix_cell (
  input  logic [1:0] gp_hi,
  input  logic [1:0] gp_lo,
  output logic [1:0] gp_o
);

  assign gp_o = {gp_hi[1] | (gp_hi[0] & gp_lo[1]), gp_hi[0] & gp_lo[0]};

endmodule

// File: rtl/prefix_addsub_pipe.sv
// Pipelined add/subtract with a Kogge-Stone carry tree; 3-cycle latency (2 without
// the output stage). All stages advance together and stall when the output is held.
module prefix_addsub_pipe
  import prefix_addsub_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PIPE_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LVL = prefix_levels(WIDTH);

  logic adv;

  // Stage 1: operands with effective b / carry-in and bitwise generate/propagate
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] a1_q, a1_d;
  logic [WIDTH-1:0] beff1_q, beff1_d;
  logic             cin1_q, cin1_d;
  logic [WIDTH-1:0] g1_q, g1_d;
  logic [WIDTH-1:0] p1_q, p1_d;

  // Stage 2: group generate/propagate over [i:0] plus what the sum step needs
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] gg2_q, gg2_d;
  logic [WIDTH-1:0] pg2_q, pg2_d;
  logic [WIDTH-1:0] hs2_q, hs2_d;
  logic             cin2_q, cin2_d;
  logic             amsb2_q, amsb2_d;
  logic             bmsb2_q, bmsb2_d;

  logic [WIDTH-1:0] beff;
  logic             cin_eff;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] res_sum;
  flags_t           res_flg;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign beff    = (mode == MODE_SUB) ? ~b : b;
  assign cin_eff = (mode == MODE_SUB) ? ~cin : cin;

  for (genvar l = 0; l < LVL; l++) begin : g_lvl
    localparam int D = 1 << l;
    logic [WIDTH-1:0] g_in, p_in, g_out, p_out;

    if (l == 0) begin : g_src0
      assign g_in = g1_q;
      assign p_in = p1_q;
    end else begin : g_srcn
      assign g_in = g_lvl[l-1].g_out;
      assign p_in = g_lvl[l-1].p_out;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_cell
        prefix_cell u_cell (
          .gp_hi ({g_in[i], p_in[i]}),
          .gp_lo ({g_in[i-D], p_in[i-D]}),
          .gp_o  ({g_out[i], p_out[i]})
        );
      end else begin : g_pass
        assign g_out[i] = g_in[i];
        assign p_out[i] = p_in[i];
      end
    end
  end

  always_comb begin
    v1_d    = v1_q;
    a1_d    = a1_q;
    beff1_d = beff1_q;
    cin1_d  = cin1_q;
    g1_d    = g1_q;
    p1_d    = p1_q;
    v2_d    = v2_q;
    gg2_d   = gg2_q;
    pg2_d   = pg2_q;
    hs2_d   = hs2_q;
    cin2_d  = cin2_q;
    amsb2_d = amsb2_q;
    bmsb2_d = bmsb2_q;
    if (adv) begin
      v1_d    = in_valid;
      a1_d    = a;
      beff1_d = beff;
      cin1_d  = cin_eff;
      g1_d    = a & beff;
      p1_d    = a ^ beff;
      v2_d    = v1_q;
      gg2_d   = g_lvl[LVL-1].g_out;
      pg2_d   = g_lvl[LVL-1].p_out;
      hs2_d   = a1_q ^ beff1_q;
      cin2_d  = cin1_q;
      amsb2_d = a1_q[WIDTH-1];
      bmsb2_d = beff1_q[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  always_ff @(posedge clk) begin
    a1_q    <= a1_d;
    beff1_q <= beff1_d;
    cin1_q  <= cin1_d;
    g1_q    <= g1_d;
    p1_q    <= p1_d;
    gg2_q   <= gg2_d;
    pg2_q   <= pg2_d;
    hs2_q   <= hs2_d;
    cin2_q  <= cin2_d;
    amsb2_q <= amsb2_d;
    bmsb2_q <= bmsb2_d;
  end

  // Carry into bit i is the group term over [i-1:0] with the external carry folded in.
  always_comb begin
    carry        = {gg2_q[WIDTH-2:0] | (pg2_q[WIDTH-2:0] & {(WIDTH-1){cin2_q}}), cin2_q};
    res_sum      = hs2_q ^ carry;
    res_flg.cout = gg2_q[WIDTH-1] | (pg2_q[WIDTH-1] & cin2_q);
    res_flg.ovf  = (amsb2_q == bmsb2_q) && (res_sum[WIDTH-1] != amsb2_q);
    res_flg.zero = ~|res_sum;
  end

  if (PIPE_OUT != 0) begin : g_out_reg
    logic             v3_q, v3_d;
    logic [WIDTH-1:0] sum3_q, sum3_d;
    flags_t           flg3_q, flg3_d;

    always_comb begin
      v3_d   = v3_q;
      sum3_d = sum3_q;
      flg3_d = flg3_q;
      if (adv) begin
        v3_d   = v2_q;
        sum3_d = res_sum;
        flg3_d = res_flg;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v3_q   <= 1'b0;
        sum3_q <= '0;
        flg3_q <= '0;
      end else begin
        v3_q   <= v3_d;
        sum3_q <= sum3_d;
        flg3_q <= flg3_d;
      end
    end

    assign out_valid = v3_q;
    assign sum       = sum3_q;
    assign cout      = flg3_q.cout;
    assign ovf       = flg3_q.ovf;
    assign zero      = flg3_q.zero;
  end else begin : g_out_comb
    // Stage-2 data is not reset, so results are masked until a valid word is present.
    assign out_valid = v2_q;
    assign sum       = v2_q ? res_sum : '0;
    assign cout      = v2_q & res_flg.cout;
    assign ovf       = v2_q & res_flg.ovf;
    assign zero      = v2_q & res_flg.zero;
  end

endmodule
